// File: rtl/nios_avalon_pkg.sv
// Shared types and constants for the Nios Avalon-MM block reader.
package nios_avalon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [3:0] AVM_BE_ALL = 4'hF;

endpackage

// File: rtl/nios_sync_fifo.sv
// Synchronous FIFO with register-array storage; the head word is presented
// straight from a flop, so data pushed in one cycle is visible the next.
module nios_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the stream data output reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nios_avalon_block_reader.sv
// Avalon-MM pipelined block read master streaming words out over valid/ready,
// with outstanding reads bounded by credits so the response buffer never overflows.
module nios_avalon_block_reader
    import nios_avalon_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  popped_q, popped_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [CW-1:0]     pending_q, pending_d;
    logic              done_q, done_d;

    logic              accept;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count_unused;

    assign avm_byteenable = AVM_BE_ALL;
    assign avm_address    = addr_q;
    assign avm_read       = (state_q == ISSUE) && (credit_q < CW'(FIFO_DEPTH));
    assign accept         = avm_read && !avm_waitrequest;
    assign st_valid       = !fifo_empty;
    assign pop            = st_valid && st_ready;
    assign st_last        = st_valid && (popped_q == length_q - LEN_W'(1));
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

    // Strobes arriving with nothing outstanding (e.g. stale after reset) are dropped.
    assign push = avm_readdatavalid && (pending_q != '0) && !fifo_full;

    nios_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (avm_readdata),
        .pop       (pop),
        .pop_data  (st_data),
        .count     (fifo_count_unused),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        length_d = length_q;
        issued_d = issued_q;
        popped_d = pop ? popped_q + LEN_W'(1) : popped_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    length_d = length;
                    issued_d = '0;
                    popped_d = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q == length_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && st_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit covers reads in flight plus words buffered; pending covers in flight only.
    always_comb begin
        credit_d  = credit_q;
        pending_d = pending_q;
        case ({accept, pop})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
        case ({accept, push})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            length_q  <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            credit_q  <= '0;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            length_q  <= length_d;
            issued_q  <= issued_d;
            popped_q  <= popped_d;
            credit_q  <= credit_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_nios_avalon_block_reader.sv
// Self-checking bench: latency-1 slave model, scoreboard queues, transfer table.
module tb_nios_avalon_block_reader;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 11;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready = 1'b0;
    logic              st_last;

    nios_avalon_block_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_last           (st_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        int                ready_mode;
        int                wait_mode;
        int                exp_first_valid;
        int                exp_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;
    int wait_mode = 0;
    int accept_count = 0;
    int read_cycles = 0;

    word_t             exp_word_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return {~a, a, 2'b10, a};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Slave model, consumer and stream/bus monitors, all evaluated mid-cycle.
    initial begin
        logic              acc_prev;
        logic [ADDR_W-1:0] addr_prev;
        logic              stall_prev;
        logic [ADDR_W-1:0] stall_addr;
        logic              hold_prev;
        logic [DATA_W-1:0] hold_data;
        logic              hold_last;
        word_t             w;
        acc_prev   = 1'b0;
        addr_prev  = '0;
        stall_prev = 1'b0;
        stall_addr = '0;
        hold_prev  = 1'b0;
        hold_data  = '0;
        hold_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc_prev          = 1'b0;
                stall_prev        = 1'b0;
                hold_prev         = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
                st_ready          = 1'b0;
                continue;
            end
            avm_readdatavalid = acc_prev;
            avm_readdata      = acc_prev ? memWord(addr_prev) : 32'hDEAD_BEEF;
            avm_waitrequest   = (wait_mode == 2) ? 1'($urandom_range(0, 1)) : (wait_mode == 1);
            st_ready          = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);

            if (stall_prev) begin
                checkOutput("stall_read", 64'(avm_read), 64'(1));
                checkOutput("stall_addr", 64'(avm_address), 64'(stall_addr));
            end
            if (hold_prev) begin
                checkOutput("hold_valid", 64'(st_valid), 64'(1));
                checkOutput("hold_data", 64'(st_data), 64'(hold_data));
                checkOutput("hold_last", 64'(st_last), 64'(hold_last));
            end

            if (avm_read) read_cycles++;
            acc_prev   = avm_read && !avm_waitrequest;
            addr_prev  = avm_address;
            stall_prev = avm_read && avm_waitrequest;
            stall_addr = avm_address;
            if (acc_prev) begin
                accept_count++;
                if (exp_addr_q.size() == 0) failNow("unexpected_read");
                else checkOutput("read_addr", 64'(avm_address), 64'(exp_addr_q.pop_front()));
            end

            if (st_valid && st_ready) begin
                if (exp_word_q.size() == 0) begin
                    failNow("unexpected_word");
                end else begin
                    w = exp_word_q.pop_front();
                    checkOutput("st_data", 64'(st_data), 64'(w.data));
                    checkOutput("st_last", 64'(st_last), 64'(w.last));
                end
            end
            hold_prev = st_valid && !st_ready;
            hold_data = st_data;
            hold_last = st_last;
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            a = b + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_word_q.push_back('{memWord(a), (i == int'(n) - 1)});
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) failNow({tag, "_done_timeout"});
    endtask

    task automatic runTransfer(input vec_t v);
        int cyc;
        int first_valid;
        int done_cyc;
        int read0;
        int busy_seen;
        logic busy_at_done;
        ready_mode   = v.ready_mode;
        wait_mode    = v.wait_mode;
        read0        = read_cycles;
        busy_seen    = 0;
        busy_at_done = 1'b1;
        applyStimulus(v.base, v.len);
        cyc         = 0;
        first_valid = -1;
        done_cyc    = -1;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1 && v.exp_first_valid >= 0) begin
                checkOutput("read_in_cycle1", 64'(avm_read), 64'(1));
                checkOutput("addr_in_cycle1", 64'(avm_address), 64'(v.base));
            end
            if (st_valid && first_valid < 0) first_valid = cyc;
            if (busy) busy_seen = 1;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
        if (done_cyc < 0) begin
            failNow("transfer_done_timeout");
        end else begin
            checkOutput("busy_at_done", 64'(busy_at_done), 64'(0));
            if (v.exp_done >= 0) checkOutput("done_cycle", 64'(done_cyc), 64'(v.exp_done));
            if (v.exp_first_valid >= 0) checkOutput("first_valid_cycle", 64'(first_valid), 64'(v.exp_first_valid));
        end
        checkOutput("busy_seen", 64'(busy_seen), 64'(v.len != 0));
        if (v.len == 0) checkOutput("zero_len_reads", 64'(read_cycles - read0), 64'(0));
        @(negedge clk);
        checkOutput("done_pulse_width", 64'(done), 64'(0));
        checkOutput("words_left", 64'(exp_word_q.size()), 64'(0));
        checkOutput("addrs_left", 64'(exp_addr_q.size()), 64'(0));
    endtask

    initial begin
        vec_t vecs[5];
        vec_t fresh;
        int   acc0;

        vecs[0] = '{10'h010, 11'd8,  1, 0,  3, 11};
        vecs[1] = '{10'h3FE, 11'd4,  1, 0,  3,  7};
        vecs[2] = '{10'h100, 11'd16, 2, 2, -1, -1};
        vecs[3] = '{10'h200, 11'd1,  1, 0,  3,  4};
        vecs[4] = '{10'h000, 11'd0,  1, 0, -1,  1};

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_read", 64'(avm_read), 64'(0));
        checkOutput("rst_addr", 64'(avm_address), 64'(0));
        checkOutput("rst_valid", 64'(st_valid), 64'(0));
        checkOutput("rst_data", 64'(st_data), 64'(0));
        checkOutput("byteenable", 64'(avm_byteenable), 64'(4'hF));
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            $display("[TB] transfer %0d base %0h len %0d", i, vecs[i].base, vecs[i].len);
            runTransfer(vecs[i]);
        end

        // Backpressure: credits cap accepted reads at the buffer depth.
        $display("[TB] backpressure with length 10");
        ready_mode = 0;
        wait_mode  = 0;
        acc0       = accept_count;
        applyStimulus(10'h040, 11'd10);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        base_addr = 10'h300;
        length    = 11'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_accepts", 64'(accept_count - acc0), 64'(FIFO_DEPTH));
        checkOutput("held_read_off", 64'(avm_read), 64'(0));
        checkOutput("held_busy", 64'(busy), 64'(1));
        checkOutput("held_head", 64'(st_data), 64'(memWord(10'h040)));
        ready_mode = 1;
        waitDone("backpressure", 200);
        @(negedge clk);
        checkOutput("bp_accepts", 64'(accept_count - acc0), 64'(10));
        checkOutput("bp_words_left", 64'(exp_word_q.size()), 64'(0));

        // Asynchronous reset in the middle of a 16-word transfer.
        $display("[TB] reset mid-transfer");
        ready_mode = 1;
        wait_mode  = 0;
        applyStimulus(10'h080, 11'd16);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_read", 64'(avm_read), 64'(0));
        checkOutput("mid_rst_addr", 64'(avm_address), 64'(0));
        checkOutput("mid_rst_valid", 64'(st_valid), 64'(0));
        checkOutput("mid_rst_last", 64'(st_last), 64'(0));
        checkOutput("mid_rst_data", 64'(st_data), 64'(0));
        checkOutput("mid_rst_done", 64'(done), 64'(0));
        exp_addr_q.delete();
        exp_word_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        fresh = '{10'h0F0, 11'd5, 1, 0, 3, 8};
        runTransfer(fresh);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
